wm_cycle_fsm: RTL and testbench
===============================

// Module: wm_cycle_fsm
// PURPOSE
//   Main wash-cycle sequencer. Drives the 3-bit state bus into the phase Timer.
//   Consumes the Timer's sig_Full, sig_Temperature and sig_Completed.
//   Moore machine: decodes state into actuator enables (valve, heater, motor, drain, door lock).
//   Adds a repeated-rinse count, a cancel/drain path and a per-phase watchdog.
// PARAMETERS
//   RINSE_CYCLES  2    number of fill+rinse passes, >=1
//   LOCK_CYCLES   4    cycles in DOOR_LOCK before filling, >=1
//   WDOG_CYCLES   1024 max cycles in any phase (2..6) before fault, >=2
// PORTS
//   clock            in   1  system clock, all logic on posedge
//   reset            in   1  synchronous, active-high
//   start            in   1  level; begin cycle from IDLE
//   cancel           in   1  level; abort running cycle via drain/spin
//   door_closed      in   1  door sensor, 1 = closed
//   sig_Full         in   1  Timer: fill phase finished
//   sig_Temperature  in   1  Timer: heat phase finished
//   sig_Completed    in   1  Timer: wash/rinse/spin phase finished
//   state            out  3  current state, to Timer
//   water_valve      out  1  inlet valve enable
//   heater           out  1  heater enable
//   motor            out  1  drum motor enable
//   motor_fast       out  1  spin speed select
//   drain_pump       out  1  drain pump enable
//   door_lock        out  1  door latch engaged
//   done             out  1  cycle finished (normal, aborted or fault)
//   aborted          out  1  sticky: last cycle ended by cancel
//   fault            out  1  sticky: last cycle ended by watchdog
// BEHAVIOUR
//   State encoding: IDLE=0, DOOR_LOCK=1, FILL_WATER=2, HEAT_WATER=3, WASH=4, RINSE=5, SPIN=6, DONE=7.
//   Reset: state=IDLE; rinse_cnt=0, wdog=0, aborted=0, fault=0; all outputs 0.
//   Outputs are decoded from the state register only. No extra latency.
//   - water_valve=FILL; heater=HEAT; motor=WASH|RINSE|SPIN.
//   - motor_fast=drain_pump=SPIN; door_lock=states 1..6; done=DONE.
//   Transitions, one per cycle, evaluated on posedge. Priority: reset > cancel > watchdog > normal.
//   - IDLE: start&door_closed -> DOOR_LOCK; clear aborted, fault, rinse_cnt.
//   - DOOR_LOCK: !door_closed -> IDLE. After LOCK_CYCLES cycles in state -> FILL_WATER.
//   - FILL_WATER: sig_Full -> HEAT_WATER if rinse_cnt==0, else -> RINSE.
//   - HEAT_WATER: sig_Temperature -> WASH.
//   - WASH: sig_Completed -> FILL_WATER; rinse_cnt=1.
//   - RINSE: on sig_Completed:
//       rinse_cnt<RINSE_CYCLES -> FILL_WATER, rinse_cnt+1;
//       otherwise -> SPIN.
//   - SPIN: sig_Completed -> DONE.
//   - DONE: !door_closed -> IDLE. done, aborted, fault hold until then; flags stay sticky into IDLE.
//   Only the completion input for the current state is honoured; all others are ignored.
//   Cancel:
//   - In 1 -> IDLE. In 2..5 -> SPIN with aborted=1. In SPIN: no effect.
//   - In 0 or 7: ignored.
//   Watchdog (wdog):
//   - Clears on every state change; increments each cycle in states 2..6.
//   - wdog==WDOG_CYCLES-1 with no honoured completion -> DONE with fault=1.
//   - If completion and timeout occur in the same cycle, completion wins.
//   Door open in states 2..6 is ignored; the door is locked.
//   reset asserted mid-cycle -> IDLE on the next edge; all actuators off that edge.
//   Counter widths: $clog2 of the parameter + 1. No wrap is reachable.
// TESTING
//   1 Reset, then start=1, door_closed=1 -> state 1 for 4 cycles -> 2; door_lock=1, water_valve=1.
//   2 Full cycle, RINSE_CYCLES=2, pulse each completion:
//       states 0,1,2,3,4,2,5,2,5,6,7;
//       done=1; open door -> IDLE.
//   3 cancel=1 in HEAT_WATER -> next cycle SPIN, drain_pump=1.
//       sig_Completed -> DONE, aborted=1, fault=0.
//   4 WDOG_CYCLES=16, hold sig_Full=0 in FILL_WATER -> DONE after 16 cycles, fault=1.
//       Repeat with sig_Full on cycle 16 -> HEAT_WATER, fault=0.
//   5 sig_Completed=1 during FILL_WATER -> no transition.
//       door opens in DOOR_LOCK -> IDLE, door_lock=0.
//   6 reset=1 while in RINSE -> next edge state=0, all outputs 0.
//       start=1 again -> aborted and fault cleared.

Source files
------------

// File: rtl/wm_cycle_fsm_if.sv
// Signal bundle between the wash-cycle sequencer and its environment
// (operator inputs, phase Timer handshake and actuator enables).
interface wm_cycle_fsm_if;
  logic       start;
  logic       cancel;
  logic       door_closed;
  logic       sig_Full;
  logic       sig_Temperature;
  logic       sig_Completed;
  logic [2:0] state;
  logic       water_valve;
  logic       heater;
  logic       motor;
  logic       motor_fast;
  logic       drain_pump;
  logic       door_lock;
  logic       done;
  logic       aborted;
  logic       fault;

  modport master (
    input  start, cancel, door_closed, sig_Full, sig_Temperature, sig_Completed,
    output state, water_valve, heater, motor, motor_fast, drain_pump,
           door_lock, done, aborted, fault
  );

  modport slave (
    output start, cancel, door_closed, sig_Full, sig_Temperature, sig_Completed,
    input  state, water_valve, heater, motor, motor_fast, drain_pump,
           door_lock, done, aborted, fault
  );
endinterface

// File: rtl/wm_cycle_fsm.sv
// Wash-cycle sequencer: Moore FSM with repeated rinse, cancel-to-drain path
// and a per-phase watchdog; actuator enables are decoded from the state register.
module wm_cycle_fsm #(
  parameter int RINSE_CYCLES = 2,
  parameter int LOCK_CYCLES  = 4,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic          clock,
  input  logic          reset,
  wm_cycle_fsm_if.master bus
);

  localparam int RW = $clog2(RINSE_CYCLES) + 1;
  localparam int LW = $clog2(LOCK_CYCLES) + 1;
  localparam int WW = $clog2(WDOG_CYCLES) + 1;
  localparam logic [RW-1:0] RINSE_MAX = RW'(RINSE_CYCLES);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOCK  = 3'd1,
    S_FILL  = 3'd2,
    S_HEAT  = 3'd3,
    S_WASH  = 3'd4,
    S_RINSE = 3'd5,
    S_SPIN  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rinse_q, rinse_d;
  logic [LW-1:0] lock_q;
  logic [WW-1:0] wdog_q;
  logic          aborted_q, aborted_d;
  logic          fault_q, fault_d;
  logic          fin, active, timeout;

  always_comb begin
    fin       = 1'b0;
    state_d   = state_q;
    rinse_d   = rinse_q;
    aborted_d = aborted_q;
    fault_d   = fault_q;

    // Only the completion belonging to the current phase is honoured.
    case (state_q)
      S_FILL:                fin = bus.sig_Full;
      S_HEAT:                fin = bus.sig_Temperature;
      S_WASH, S_RINSE, S_SPIN: fin = bus.sig_Completed;
      default:               fin = 1'b0;
    endcase

    active  = (state_q inside {S_FILL, S_HEAT, S_WASH, S_RINSE, S_SPIN});
    timeout = active && !fin && (wdog_q == WDOG_LAST);

    if (bus.cancel && state_q == S_LOCK) begin
      state_d = S_IDLE;
    end else if (bus.cancel && (state_q inside {S_FILL, S_HEAT, S_WASH, S_RINSE})) begin
      state_d   = S_SPIN;
      aborted_d = 1'b1;
    end else if (timeout) begin
      state_d = S_DONE;
      fault_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:
          if (bus.start && bus.door_closed) begin
            state_d   = S_LOCK;
            aborted_d = 1'b0;
            fault_d   = 1'b0;
            rinse_d   = '0;
          end
        S_LOCK:
          if (!bus.door_closed)       state_d = S_IDLE;
          else if (lock_q == LOCK_LAST) state_d = S_FILL;
        S_FILL:
          if (fin) state_d = (rinse_q == '0) ? S_HEAT : S_RINSE;
        S_HEAT:
          if (fin) state_d = S_WASH;
        S_WASH:
          if (fin) begin
            state_d = S_FILL;
            rinse_d = RW'(1);
          end
        S_RINSE:
          if (fin) begin
            if (rinse_q < RINSE_MAX) begin
              state_d = S_FILL;
              rinse_d = rinse_q + 1'b1;
            end else begin
              state_d = S_SPIN;
            end
          end
        S_SPIN:
          if (fin) state_d = S_DONE;
        S_DONE:
          if (!bus.door_closed) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rinse_q   <= '0;
      lock_q    <= '0;
      wdog_q    <= '0;
      aborted_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rinse_q   <= rinse_d;
      aborted_q <= aborted_d;
      fault_q   <= fault_d;
      // Both phase timers restart whenever the state changes.
      if (state_d != state_q) begin
        lock_q <= '0;
        wdog_q <= '0;
      end else begin
        if (state_q == S_LOCK) lock_q <= lock_q + 1'b1;
        if (active)            wdog_q <= wdog_q + 1'b1;
      end
    end
  end

  assign bus.state       = state_q;
  assign bus.water_valve = (state_q == S_FILL);
  assign bus.heater      = (state_q == S_HEAT);
  assign bus.motor       = (state_q inside {S_WASH, S_RINSE, S_SPIN});
  assign bus.motor_fast  = (state_q == S_SPIN);
  assign bus.drain_pump  = (state_q == S_SPIN);
  assign bus.door_lock   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.aborted     = aborted_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_wm_cycle_fsm.sv
// Randomized bench for wm_cycle_fsm, checked cycle by cycle against a
// behavioural model driven by a single time-in-state counter.
module tb_wm_cycle_fsm;
  localparam int RINSE = 2;
  localparam int LOCK  = 4;
  localparam int WDOG  = 16;

  logic clock = 1'b0;
  logic reset;
  wm_cycle_fsm_if bus();

  wm_cycle_fsm #(
    .RINSE_CYCLES(RINSE),
    .LOCK_CYCLES (LOCK),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_state = 0;
  int m_age   = 0;
  int m_rinse = 0;
  bit m_ab    = 1'b0;
  bit m_ft    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int nxt;
    bit fin;
    bit in_phase;
    if (reset) begin
      m_state = 0; m_age = 0; m_rinse = 0; m_ab = 1'b0; m_ft = 1'b0;
      return;
    end
    nxt      = m_state;
    in_phase = (m_state >= 2) && (m_state <= 6);
    fin = (m_state == 2 && bus.sig_Full) ||
          (m_state == 3 && bus.sig_Temperature) ||
          (m_state >= 4 && m_state <= 6 && bus.sig_Completed);
    if (bus.cancel && m_state == 1) nxt = 0;
    else if (bus.cancel && m_state >= 2 && m_state <= 5) begin nxt = 6; m_ab = 1'b1; end
    else if (in_phase && !fin && m_age == WDOG - 1) begin nxt = 7; m_ft = 1'b1; end
    else begin
      case (m_state)
        0: if (bus.start && bus.door_closed) begin
             nxt = 1; m_ab = 1'b0; m_ft = 1'b0; m_rinse = 0;
           end
        1: if (!bus.door_closed) nxt = 0;
           else if (m_age == LOCK - 1) nxt = 2;
        2: if (fin) nxt = (m_rinse == 0) ? 3 : 5;
        3: if (fin) nxt = 4;
        4: if (fin) begin nxt = 2; m_rinse = 1; end
        5: if (fin) begin
             if (m_rinse < RINSE) begin nxt = 2; m_rinse = m_rinse + 1; end
             else nxt = 6;
           end
        6: if (fin) nxt = 7;
        default: if (!bus.door_closed) nxt = 0;
      endcase
    end
    m_age   = (nxt == m_state) ? m_age + 1 : 0;
    m_state = nxt;
  endtask

  task automatic check_outputs();
    logic [6:0] exp_act;
    logic [6:0] got_act;
    exp_act = {m_state == 2, m_state == 3, (m_state >= 4 && m_state <= 6),
               m_state == 6, m_state == 6, (m_state >= 1 && m_state <= 6),
               m_state == 7};
    got_act = {bus.water_valve, bus.heater, bus.motor, bus.motor_fast,
               bus.drain_pump, bus.door_lock, bus.done};
    chk("state",   32'(bus.state),  32'(m_state));
    chk("act",     32'(got_act),    32'(exp_act));
    chk("aborted", 32'(bus.aborted), 32'(m_ab));
    chk("fault",   32'(bus.fault),   32'(m_ft));
  endtask

  // Probabilities are per-mille per cycle.
  task automatic run_phase(input int n, input int p_start, input int p_cancel,
                           input int p_open, input int p_comp, input int p_rst);
    for (int i = 0; i < n; i++) begin
      reset               = ($urandom_range(999) < p_rst);
      bus.start           = ($urandom_range(999) < p_start);
      bus.cancel          = ($urandom_range(999) < p_cancel);
      bus.door_closed     = !($urandom_range(999) < p_open);
      bus.sig_Full        = ($urandom_range(999) < p_comp);
      bus.sig_Temperature = ($urandom_range(999) < p_comp);
      bus.sig_Completed   = ($urandom_range(999) < p_comp);
      model_step();
      @(negedge clock);
      check_outputs();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.door_closed = 1'b1;
    bus.sig_Full = 1'b0; bus.sig_Temperature = 1'b0; bus.sig_Completed = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_step();
      @(negedge clock);
      check_outputs();
    end
    // Normal cycles: frequent completions, no cancel, door opens sometimes
    run_phase(400, 700, 0, 120, 300, 0);
    // Slow Timer: watchdog timeouts and completion-at-deadline races
    run_phase(700, 700, 0, 100, 60, 0);
    // Cancels in every phase
    run_phase(700, 700, 40, 100, 150, 0);
    // Everything mixed, including mid-cycle resets
    run_phase(1200, 500, 20, 150, 120, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
